// File: rtl/frame_pkg.sv
// Shared definitions for the 1101 serial link: the frame state encoding,
// the default sync pattern, and small constant helpers for sizing counters.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } frame_state_e;

    localparam int         SYNC_W_DEF   = 4;
    localparam logic [3:0] SYNC_PAT_DEF = 4'b1101;

    // Number of bits needed to hold the values 0 .. value-1
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, serial-out shift register. The most significant bit is
// always presented on msb_o; each shift moves the next lower bit into place.
module piso_shreg
    import frame_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    // Load takes priority over shift; otherwise the word holds its value
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = shreg_q << 1;
        end
    end

    // Word register, cleared so an aborted frame leaves no stale payload
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[DATA_W-1];

endmodule

// File: rtl/frame_tx_1101.sv
// Serial frame transmitter: accepts a payload word over valid/ready, then
// sends the sync pattern and the payload MSB-first, followed by a run of
// forced-zero gap bits. Every output is a registered function of state.
module frame_tx_1101
    import frame_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF),
    parameter int                GAP      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_out,
    output logic              frame_active,
    output logic              tx_done
);

    localparam int CNT_W = clog2(max4(DATA_W, SYNC_W, GAP, 2));

    frame_state_e       state_q;
    frame_state_e       state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               data_out_q;
    logic               data_out_d;
    logic               frame_active_q;
    logic               frame_active_d;
    logic               tx_done_q;
    logic               tx_done_d;
    logic               tx_ready_q;
    logic               tx_ready_d;

    logic               accept;
    logic               shiftEn;
    logic               shregMsb;
    logic [SYNC_W-1:0]  syncBits;

    // Payload storage; loaded on accept, shifted once per payload bit sent
    piso_shreg #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (shiftEn),
        .data_i  (tx_data),
        .msb_o   (shregMsb)
    );

    // Next state and bit counter; the counter always holds the index of the bit being shown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_SYNC;
                    cnt_d   = CNT_W'(SYNC_W - 1);
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PAYLOAD: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP - 1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        data_out_d     = 1'b0;
        frame_active_d = 1'b0;
        tx_done_d      = 1'b0;
        tx_ready_d     = 1'b0;
        shiftEn        = 1'b0;
        syncBits       = SYNC_PAT >> cnt_d;
        case (state_d)
            ST_IDLE: begin
                tx_ready_d = 1'b1;
            end
            ST_SYNC: begin
                data_out_d     = syncBits[0];
                frame_active_d = 1'b1;
            end
            ST_PAYLOAD: begin
                data_out_d     = shregMsb;
                frame_active_d = 1'b1;
                tx_done_d      = (cnt_d == '0);
                shiftEn        = 1'b1;
            end
            default: begin
                data_out_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            data_out_q     <= 1'b0;
            frame_active_q <= 1'b0;
            tx_done_q      <= 1'b0;
            tx_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_out_q     <= data_out_d;
            frame_active_q <= frame_active_d;
            tx_done_q      <= tx_done_d;
            tx_ready_q     <= tx_ready_d;
        end
    end

    assign tx_ready     = tx_ready_q;
    assign data_out     = data_out_q;
    assign frame_active = frame_active_q;
    assign tx_done      = tx_done_q;

endmodule

// File: tb/tb_frame_tx_1101.sv
// Bench for frame_tx_1101: a stimulus process queues the expected frame bits
// at every accept, and a monitor pops and compares whenever a frame bit is
// presented. Directed checks cover reset, busy/gap timing and a 1101 loopback.
module tb_frame_tx_1101;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       data_out;
    logic       frame_active;
    logic       tx_done;

    typedef struct packed {
        logic bitVal;
        logic done;
    } exp_bit_t;

    exp_bit_t expQ[$];
    int       checkCount = 0;
    int       passCount  = 0;

    logic [3:0] detHist;
    logic       detOut;

    frame_tx_1101 dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .data_out     (data_out),
        .frame_active (frame_active),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    // Reference Moore 1101 detector fed from the serial line
    always @(posedge clk) begin
        if (rst) detHist <= 4'b0000;
        else     detHist <= {detHist[2:0], data_out};
    end
    assign detOut = (detHist == 4'b1101);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Queue sync 1101 then payload MSB-first, done flag on the final bit
    task automatic pushFrame(input logic [7:0] data);
        logic [3:0] syncPat;
        exp_bit_t   e;
        syncPat = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            e.bitVal = syncPat[i];
            e.done   = 1'b0;
            expQ.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            e.bitVal = data[i];
            e.done   = (i == 0);
            expQ.push_back(e);
        end
    endtask

    // Wait (bounded) for ready, then present one word; returns 1ns after the accept edge
    task automatic applyStimulus(input logic [7:0] data, input bit keepValid);
        int waitCount;
        waitCount = 0;
        while (tx_ready !== 1'b1 && waitCount < 50) begin
            nextCycle();
            waitCount++;
        end
        if (tx_ready !== 1'b1) checkOutput("ready timeout", {31'd0, tx_ready}, 32'd1);
        tx_data  = data;
        tx_valid = 1'b1;
        pushFrame(data);
        nextCycle();
        if (!keepValid) tx_valid = 1'b0;
    endtask

    // Monitor: every presented frame bit is compared against the queue head
    always @(negedge clk) begin
        exp_bit_t e;
        if (frame_active === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected frame bit", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("data_out", {31'd0, data_out}, {31'd0, e.bitVal});
                checkOutput("tx_done", {31'd0, tx_done}, {31'd0, e.done});
            end
        end else if (tx_done !== 1'b0) begin
            checkOutput("tx_done outside frame", {31'd0, tx_done}, 32'd0);
        end
    end

    // One A5-style frame with cycle-accurate busy/gap checks, optionally poking tx_valid while busy
    task automatic runSingle(input logic [7:0] data, input bit pulseBusy);
        applyStimulus(data, 1'b0);
        for (int i = 0; i < 14; i++) begin
            checkOutput("ready low while busy", {31'd0, tx_ready}, 32'd0);
            checkOutput("frame_active window", {31'd0, frame_active}, (i < 12) ? 32'd1 : 32'd0);
            if (i >= 12) checkOutput("gap bit zero", {31'd0, data_out}, 32'd0);
            if (pulseBusy && i == 5) begin
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
            end
            if (pulseBusy && i == 6) tx_valid = 1'b0;
            nextCycle();
        end
        checkOutput("ready after gap", {31'd0, tx_ready}, 32'd1);
        checkOutput("idle bit zero", {31'd0, data_out}, 32'd0);
        for (int i = 0; i < 20; i++) nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset: held for two edges, outputs quiet and not ready
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset data_out", {31'd0, data_out}, 32'd0);
        checkOutput("reset frame_active", {31'd0, frame_active}, 32'd0);
        checkOutput("reset tx_done", {31'd0, tx_done}, 32'd0);
        checkOutput("reset tx_ready", {31'd0, tx_ready}, 32'd0);
        rst = 1'b0;
        nextCycle();
        checkOutput("ready after reset", {31'd0, tx_ready}, 32'd1);
        checkOutput("idle data_out", {31'd0, data_out}, 32'd0);

        // Single frame, then the same with a busy-time tx_valid pulse
        runSingle(8'hA5, 1'b0);
        runSingle(8'hA5, 1'b1);

        // Back-to-back: valid held high, data switched right after the first accept
        applyStimulus(8'hFF, 1'b1);
        tx_data = 8'h00;
        pushFrame(8'h00);
        for (int i = 0; i < 30; i++) begin
            checkOutput("b2b frame_active", {31'd0, frame_active},
                        ((i < 12) || (i >= 15 && i < 27)) ? 32'd1 : 32'd0);
            checkOutput("b2b tx_ready", {31'd0, tx_ready}, (i == 14 || i == 29) ? 32'd1 : 32'd0);
            if (i == 15) tx_valid = 1'b0;
            nextCycle();
        end
        for (int i = 0; i < 5; i++) nextCycle();

        // Reset during the 6th bit of an A5 frame
        applyStimulus(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) nextCycle();
        rst = 1'b1;
        nextCycle();
        expQ.delete();
        checkOutput("abort data_out", {31'd0, data_out}, 32'd0);
        checkOutput("abort frame_active", {31'd0, frame_active}, 32'd0);
        checkOutput("abort tx_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        nextCycle();
        checkOutput("ready after abort", {31'd0, tx_ready}, 32'd1);
        applyStimulus(8'h0F, 1'b0);
        for (int i = 0; i < 20; i++) nextCycle();

        // Loopback into the 1101 detector with a zero payload
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("detector out", {31'd0, detOut}, (i == 4) ? 32'd1 : 32'd0);
            nextCycle();
        end

        checkOutput("all frame bits seen", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
